// File: rtl/isa_pkg.sv
`default_nettype none
//============================================================================
// Package : isa_pkg
// ISA widths, instruction field positions, HALT opcode and fetch states.
// Rev     : 1.0
//============================================================================
package isa_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 29;
  localparam int OP_W    = 5;
  localparam int FIELD_W = 8;

  localparam int OP_MSB   = 28;
  localparam int OP_LSB   = 24;
  localparam int DEST_MSB = 23;
  localparam int DEST_LSB = 16;
  localparam int SRC1_MSB = 15;
  localparam int SRC1_LSB = 8;
  localparam int SRC2_MSB = 7;
  localparam int SRC2_LSB = 0;

  localparam logic [OP_W-1:0] OP_HALT = 5'b11111;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

endpackage
`default_nettype wire

// File: rtl/fetch_pc.sv
`default_nettype none
//============================================================================
// Module : fetch_pc
// Program counter register with redirect, increment and hold muxing.
// Rev    : 1.0
//============================================================================
module fetch_pc
  import isa_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_add,
  input  logic              i_advance,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  // Redirect wins over advance; the increment wraps naturally at 2^ADDR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
    end else if (i_redirect) begin
      r_pc <= i_redirect_add;
    end else if (i_advance) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
//============================================================================
// Module : instruction_fetch
// Fetch front end: registers instruction fields onto a valid/ready output.
// Optional feature macro: FETCH_PERF_EN (handshake counter output).
// Rev    : 1.0
//============================================================================
module instruction_fetch
  import isa_pkg::*;
(
  input  logic               in_clk,
  input  logic               in_rst_n,
  output logic [ADDR_W-1:0]  out_add,
  input  logic [INSTR_W-1:0] in_instruction,
  output logic               out_valid,
  input  logic               in_ready,
  output logic [OP_W-1:0]    out_opcode,
  output logic [FIELD_W-1:0] out_dest,
  output logic [FIELD_W-1:0] out_src1,
  output logic [FIELD_W-1:0] out_src2,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               in_redirect,
  input  logic [ADDR_W-1:0]  in_redirect_add,
  output logic               out_halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        out_fetch_count
`endif
);

  logic [0:0]         r_state;
  logic               r_valid;
  logic [OP_W-1:0]    r_opcode;
  logic [FIELD_W-1:0] r_dest;
  logic [FIELD_W-1:0] r_src1;
  logic [FIELD_W-1:0] r_src2;
  logic [ADDR_W-1:0]  r_pc;

  logic [ADDR_W-1:0]  w_add;
  logic               w_load;
  logic               w_is_halt;
  logic               w_handshake;

  assign w_is_halt   = (in_instruction[OP_MSB:OP_LSB] == OP_HALT);
  assign w_load      = (r_state == ST_RUN) && !in_redirect && (!r_valid || in_ready);
  assign w_handshake = r_valid && in_ready;

  // A HALT is presented but the PC parks on it.
  fetch_pc u_fetch_pc (
    .clk            (in_clk),
    .rst_n          (in_rst_n),
    .i_redirect     (in_redirect),
    .i_redirect_add (in_redirect_add),
    .i_advance      (w_load && !w_is_halt),
    .o_pc           (w_add)
  );

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state  <= ST_RUN;
      r_valid  <= 1'b0;
      r_opcode <= '0;
      r_dest   <= '0;
      r_src1   <= '0;
      r_src2   <= '0;
      r_pc     <= '0;
    end else if (in_redirect) begin
      r_state <= ST_RUN;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid  <= 1'b1;
      r_opcode <= in_instruction[OP_MSB:OP_LSB];
      r_dest   <= in_instruction[DEST_MSB:DEST_LSB];
      r_src1   <= in_instruction[SRC1_MSB:SRC1_LSB];
      r_src2   <= in_instruction[SRC2_MSB:SRC2_LSB];
      r_pc     <= w_add;
      if (w_is_halt) begin
        r_state <= ST_HALTED;
      end
    end else if (w_handshake) begin
      r_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] r_fetch_count;

  // Flushed instructions are excluded by gating with the redirect.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_fetch_count <= '0;
    end else if (w_handshake && !in_redirect && (r_fetch_count != 16'hFFFF)) begin
      r_fetch_count <= r_fetch_count + 16'd1;
    end
  end

  assign out_fetch_count = r_fetch_count;
`endif

  assign out_add    = w_add;
  assign out_valid  = r_valid;
  assign out_opcode = r_opcode;
  assign out_dest   = r_dest;
  assign out_src1   = r_src1;
  assign out_src2   = r_src2;
  assign out_pc     = r_pc;
  assign out_halted = (r_state == ST_HALTED);

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch front end for the processor core: it drives the 8-bit address into the asynchronous-read program memory and registers the 29-bit instruction returned in the same cycle. It splits the instruction into opcode and operand fields and presents them downstream on a valid/ready handshake. It sits between program memory and the decode/execute stage, and accepts redirects (jumps/branches) and a halt opcode.

## Interface
- ADDR_W, 8, program memory address width (256 words)
- INSTR_W, 29, instruction width
- OP_W, 5, opcode field width, bits [28:24]
- FIELD_W, 8, operand field width: dest [23:16], src1 [15:8], src2/imm [7:0]

Ports:
- in_clk  input  1  single clock, rising edge
- in_rst_n  input  1  asynchronous active-low reset
- out_add  output  ADDR_W  program counter, drives program memory address
- in_instruction  input  INSTR_W  program memory read data, combinational from out_add
- out_valid  output  1  output fields hold an unconsumed instruction
- in_ready  input  1  downstream accepts when out_valid && in_ready
- out_opcode  output  OP_W  registered opcode
- out_dest  output  FIELD_W  registered dest field
- out_src1  output  FIELD_W  registered src1 field
- out_src2  output  FIELD_W  registered src2/immediate field
- out_pc  output  ADDR_W  address the presented instruction was fetched from
- in_redirect  input  1  one-cycle request to restart fetch at in_redirect_add
- in_redirect_add  input  ADDR_W  redirect target
- out_halted  output  1  fetch stopped on HALT opcode

## Operation
- States: RUN, HALTED. Reset value: RUN.
- Load condition: state RUN && !in_redirect && (!out_valid || in_ready).
- On load: fields and out_pc take in_instruction / out_add. out_valid is set to 1. out_add increments modulo 2^ADDR_W (255 -> 0).
- Consume without load (out_valid && in_ready, no load): out_valid is cleared to 0.
- HALT opcode (OP_HALT = 5'b11111) on load: the instruction is presented normally. out_add is NOT incremented and the state becomes HALTED. No further loads occur. out_valid clears once the HALT is consumed.
- Redirect (highest priority, any state): out_add <= in_redirect_add, out_valid <= 0 (flush, the presented instruction is dropped even if in_ready=1), state <= RUN. No load occurs in the redirect cycle.
- Opcode 0 is treated as an ordinary instruction (NOP); no special handling.
- Reset values: out_add 0, out_valid 0, all fields 0, out_pc 0, out_halted 0.

## Timing
- Instruction at address A is sampled at the edge where out_add==A and the load condition holds. It is visible on the outputs in the following cycle. Latency: 1 cycle.
- Sustained throughput: 1 instruction/cycle while in_ready=1.
- With in_ready=0 and out_valid=1: out_add and all fields hold stable.
- Redirect asserted at edge N: the target instruction loads at edge N+1 and is valid after edge N+1.
- out_halted = (state == HALTED), registered.
- Asserting reset mid-stream immediately forces all reset values. The first load occurs at the first edge after release.

## Configuration
- FETCH_PERF_EN defined: adds output out_fetch_count (16 bits, reset 0). It increments on each handshake (out_valid && in_ready) and saturates at 16'hFFFF. A flushed instruction is not counted.
- FETCH_PERF_EN undefined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- Shared package isa_pkg: OP_W, FIELD_W, INSTR_W, ADDR_W, field bit positions, OP_HALT, and the fetch state enum. It is also used by program memory and decode.
- One natural sub-module, fetch_pc: the program counter register with its increment, redirect and hold muxing.

## Test plan
- Reset, memory words 1..3 preloaded, in_ready=1 -> out_valid rises 1 cycle after release. Outputs show addresses 0,1,2,3 in consecutive cycles. Word 1 appears as opcode 1, dest 2, src1 0, src2 1.
- in_ready=0 for 3 cycles while out_valid=1 -> out_add, out_pc and fields stay frozen. Releasing in_ready resumes with no skipped or duplicated address.
- in_redirect with add 8'h40 while an instruction is valid -> out_valid=0 next cycle, then out_pc=8'h40 with mem[0x40] contents.
- HALT word at 8'h05 -> presented with out_pc=5, out_halted=1, out_add stays 5. Nothing further is loaded. A redirect to 0 resumes fetching.
- out_add reaches 8'hFF with in_ready=1 -> next fetch address is 8'h00 (wrap).
- FETCH_PERF_EN defined: 10 handshakes plus 1 flushed instruction -> out_fetch_count=10. Counter saturation at 16'hFFFF is checked by forcing the count.
